mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the instruction-cache and data-cache miss/writeback traffic onto the single RAM port.
//  Sits directly downstream of the cache pair: consumes the iREN/dREN/dWEN/addr/store requests and
//  returns iwait/dwait/iload/dload. Latches the winning request, drives the RAM handshake,
//  and retries on RAM error. Keeps a saturating error count for debug.
// PARAMETERS
//  WORD_W   32  data and address width (bits)
//  ERRCNT_W 8   width of the saturating RAM-error counter
// PORTS
//  CLK       in   1        clock, all state on rising edge
//  nRST      in   1        asynchronous active-low reset
//  iREN      in   1        icache read request (held until iwait=0)
//  iaddr     in   WORD_W   icache request address
//  dREN      in   1        dcache read request (held until dwait=0)
//  dWEN      in   1        dcache write request (held until dwait=0)
//  daddr     in   WORD_W   dcache request address
//  dstore    in   WORD_W   dcache write data
//  iwait     out  1        0 = icache transfer completes this cycle
//  dwait     out  1        0 = dcache transfer completes this cycle
//  iload     out  WORD_W   read data to icache, valid when iwait=0
//  dload     out  WORD_W   read data to dcache, valid when dwait=0
//  ramREN    out  1        RAM read enable
//  ramWEN    out  1        RAM write enable
//  ramaddr   out  WORD_W   RAM address (latched request address)
//  ramstore  out  WORD_W   RAM write data (latched dstore)
//  ramload   in   WORD_W   RAM read data
//  ramstate  in   2        00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
//  err_cnt   out  ERRCNT_W number of ERROR responses seen, saturating
// BEHAVIOUR
//  - Reset (async, nRST=0): state=IDLE, last_grant=I, addr/store/we regs=0, err_cnt=0;
//    hence iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=ramload passthrough.
//    Reset mid-transfer aborts it; RAM enables drop asynchronously with nRST.
//  - States: IDLE, DSERV, ISERV, RETRY (2-bit register) + saved_d flag for RETRY return.
//  - IDLE: dREN|dWEN -> DSERV, latch daddr/dstore, we=dWEN; else iREN -> ISERV, latch iaddr;
//    else stay. Fixed priority: dcache wins simultaneous requests.
//  - DSERV/ISERV outputs: ramaddr=addr_reg; ramREN=ISERV|(DSERV&~we); ramWEN=DSERV&we;
//    ramstore=store_reg. dREN&dWEN both high at grant -> treated as write.
//  - ramstate ACCESS in DSERV: dwait=0 same cycle (combinational), dload=ramload; next IDLE.
//    ACCESS in ISERV: iwait=0, iload=ramload; next IDLE. FREE/BUSY: hold state, wait=1.
//  - ERROR: next RETRY, saved_d=(state==DSERV), err_cnt+=1 saturating at all-ones. Waits stay 1.
//  - RETRY: ramREN=ramWEN=0 for exactly one cycle, then return to DSERV/ISERV per saved_d with
//    latched request unchanged.
//  - Requester withdraws (DSERV with dREN=dWEN=0, or ISERV with iREN=0) while ramstate!=ACCESS:
//    abort to IDLE next cycle, no wait pulse. Withdraw while in RETRY: return to IDLE.
//  - Latency: request seen in IDLE cycle N -> RAM enables cycle N+1 -> wait low earliest N+1.
//    One mandatory IDLE cycle between transfers; loser of arbitration waits >=2 cycles.
//  - Outside granted service, iwait=dwait=1 always; never both low in one cycle.
// CONFIGURATION
//  ARB_FAIR_EN defined: in IDLE, if dcache and icache both request, grant the requester
//    opposite to last_grant (round-robin); single requester granted as normal; last_grant
//    updates on every grant.
//  ARB_FAIR_EN undefined: fixed dcache-over-icache priority; last_grant register not built.
// TESTING
//  1 iREN=1,iaddr=0x100, ramstate ACCESS in N+1 with ramload=0xDEADBEEF -> iwait=0 at N+1,
//    iload=0xDEADBEEF, ramREN=1 ramWEN=0 ramaddr=0x100; IDLE at N+2.
//  2 iREN=1 and dWEN=1 (daddr=0x200,dstore=0x55) same cycle -> ramWEN=1 ramaddr=0x200 first,
//    dwait=0 on ACCESS; then IDLE, then ramREN=1 ramaddr=0x100, iwait=0 on ACCESS.
//  3 dREN=1 at 0x40, ramstate BUSY 3 cycles then ERROR then ACCESS -> one cycle with
//    ramREN=0 (RETRY), reissue to 0x40, dwait=0 on ACCESS, err_cnt=1.
//  4 Force 300 ERROR responses with ERRCNT_W=8 -> err_cnt saturates at 255, no wrap.
//  5 dREN raised then dropped while ramstate BUSY -> IDLE next cycle, dwait never 0, enables 0.
//  6 ARB_FAIR_EN, iREN and dREN held continuously -> grants alternate D,I,D,I; without macro D only.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache miss/writeback traffic onto the single RAM port, retrying on RAM error.
// Optional ARB_FAIR_EN macro enables round-robin between simultaneous icache/dcache requests.
module mem_arbiter #(
    parameter int WORD_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [WORD_W-1:0]   iaddr,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [WORD_W-1:0]   daddr,
    input  logic [WORD_W-1:0]   dstore,
    output logic                iwait,
    output logic                dwait,
    output logic [WORD_W-1:0]   iload,
    output logic [WORD_W-1:0]   dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic [1:0]          ramstate,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    typedef enum logic [1:0] {IDLE, DSERV, ISERV, RETRY} state_t;

    state_t              state, state_nxt;
    logic                saved_d, saved_d_nxt;
    logic                we_reg, we_nxt;
    logic [WORD_W-1:0]   addr_reg, addr_nxt;
    logic [WORD_W-1:0]   store_reg, store_nxt;
    logic                err_hit;
    logic                dreq;
    logic                grant_d;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

    assign dreq = dREN | dWEN;

`ifdef ARB_FAIR_EN
    logic last_d, last_d_nxt;

    // last_d=0 means the icache had the last grant, so a tie goes to the dcache
    assign grant_d = dreq & (~iREN | ~last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_d <= 1'b0;
        else       last_d <= last_d_nxt;
    end

    always_comb begin
        last_d_nxt = last_d;
        if (state == IDLE) begin
            if (grant_d)   last_d_nxt = 1'b1;
            else if (iREN) last_d_nxt = 1'b0;
        end
    end
`else
    assign grant_d = dreq;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            saved_d   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            store_reg <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            saved_d   <= saved_d_nxt;
            we_reg    <= we_nxt;
            addr_reg  <= addr_nxt;
            store_reg <= store_nxt;
            if (err_hit) err_cnt <= sat_inc(err_cnt);
        end
    end

    always_comb begin
        state_nxt   = state;
        saved_d_nxt = saved_d;
        we_nxt      = we_reg;
        addr_nxt    = addr_reg;
        store_nxt   = store_reg;
        err_hit     = 1'b0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = DSERV;
                    addr_nxt  = daddr;
                    store_nxt = dstore;
                    we_nxt    = dWEN;
                end else if (iREN) begin
                    state_nxt = ISERV;
                    addr_nxt  = iaddr;
                    we_nxt    = 1'b0;
                end
            end
            DSERV: begin
                if (ramstate == RS_ACCESS) begin
                    dwait     = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    err_hit = (ramstate == RS_ERROR);
                    if (!dreq) begin
                        state_nxt = IDLE;
                    end else if (ramstate == RS_ERROR) begin
                        state_nxt   = RETRY;
                        saved_d_nxt = 1'b1;
                    end
                end
            end
            ISERV: begin
                if (ramstate == RS_ACCESS) begin
                    iwait     = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    err_hit = (ramstate == RS_ERROR);
                    if (!iREN) begin
                        state_nxt = IDLE;
                    end else if (ramstate == RS_ERROR) begin
                        state_nxt   = RETRY;
                        saved_d_nxt = 1'b0;
                    end
                end
            end
            RETRY: begin
                // One dead cycle on the RAM port, then reissue the latched request
                if (saved_d) state_nxt = dreq ? DSERV : IDLE;
                else         state_nxt = iREN ? ISERV : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ramREN   = (state == ISERV) | ((state == DSERV) & ~we_reg);
    assign ramWEN   = (state == DSERV) & we_reg;
    assign ramaddr  = addr_reg;
    assign ramstore = store_reg;
    assign iload    = ramload;
    assign dload    = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table plus hand sequences for retry, saturation,
// async reset and arbitration order.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.WORD_W(32), .ERRCNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] ia;
        logic        dren;
        logic        dwen;
        logic [31:0] da;
        logic [31:0] ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
    endtask

    initial begin
        string got;
        string exp_s;
        int lows;

        // cycle table: each row is one cycle, outputs sampled 1ns after the falling edge
        vecs[0]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,  FREE, 32'h11,       1, 1, 0, 0, 32'h0,   32'h0};
        vecs[1]  = '{1, 32'h100, 0, 0, 32'h0,   32'h0,  FREE, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0};
        vecs[2]  = '{1, 32'h100, 0, 0, 32'h0,   32'h0,  ACC,  32'hDEADBEEF, 0, 1, 1, 0, 32'h100, 32'h0};
        vecs[3]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,  FREE, 32'h0,        1, 1, 0, 0, 32'h100, 32'h0};
        vecs[4]  = '{1, 32'h100, 0, 1, 32'h200, 32'h55, FREE, 32'h0,        1, 1, 0, 0, 32'h100, 32'h0};
        vecs[5]  = '{1, 32'h100, 0, 1, 32'h200, 32'h55, BUSY, 32'h0,        1, 1, 0, 1, 32'h200, 32'h55};
        vecs[6]  = '{1, 32'h100, 0, 1, 32'h200, 32'h55, ACC,  32'h0,        1, 0, 0, 1, 32'h200, 32'h55};
        vecs[7]  = '{1, 32'h100, 0, 0, 32'h0,   32'h0,  FREE, 32'h0,        1, 1, 0, 0, 32'h200, 32'h55};
        vecs[8]  = '{1, 32'h100, 0, 0, 32'h0,   32'h0,  ACC,  32'h1234,     0, 1, 1, 0, 32'h100, 32'h55};
        vecs[9]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,  FREE, 32'h0,        1, 1, 0, 0, 32'h100, 32'h55};
        vecs[10] = '{0, 32'h0,   1, 0, 32'h80,  32'h0,  FREE, 32'h0,        1, 1, 0, 0, 32'h100, 32'h55};
        vecs[11] = '{0, 32'h0,   1, 0, 32'h80,  32'h0,  BUSY, 32'h0,        1, 1, 1, 0, 32'h80,  32'h0};
        vecs[12] = '{0, 32'h0,   0, 0, 32'h80,  32'h0,  BUSY, 32'h0,        1, 1, 1, 0, 32'h80,  32'h0};
        vecs[13] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,  ACC,  32'h77,       1, 1, 0, 0, 32'h80,  32'h0};

        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, FREE, 32'hA5A5);
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_iwait", {31'b0, iwait}, 1);
        chk("rst_dwait", {31'b0, dwait}, 1);
        chk("rst_ren", {31'b0, ramREN}, 0);
        chk("rst_wen", {31'b0, ramWEN}, 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_store", ramstore, 0);
        chk("rst_errcnt", {24'b0, err_cnt}, 0);
        chk("rst_iload", iload, 32'hA5A5);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            drive(vecs[i].iren, vecs[i].ia, vecs[i].dren, vecs[i].dwen,
                  vecs[i].da, vecs[i].ds, vecs[i].rs, vecs[i].rl);
            #1;
            chk($sformatf("v%0d_iwait", i), {31'b0, iwait}, {31'b0, vecs[i].e_iwait});
            chk($sformatf("v%0d_dwait", i), {31'b0, dwait}, {31'b0, vecs[i].e_dwait});
            chk($sformatf("v%0d_ren", i), {31'b0, ramREN}, {31'b0, vecs[i].e_ren});
            chk($sformatf("v%0d_wen", i), {31'b0, ramWEN}, {31'b0, vecs[i].e_wen});
            chk($sformatf("v%0d_addr", i), ramaddr, vecs[i].e_addr);
            chk($sformatf("v%0d_store", i), ramstore, vecs[i].e_store);
            chk($sformatf("v%0d_iload", i), iload, vecs[i].rl);
            chk($sformatf("v%0d_dload", i), dload, vecs[i].rl);
        end

        // BUSY x3, ERROR, RETRY gap, then ACCESS on reissue
        @(negedge CLK); drive(0, 0, 1, 0, 32'h40, 0, FREE, 0); #1;
        chk("t3_idle_dwait", {31'b0, dwait}, 1);
        repeat (3) begin
            @(negedge CLK); ramstate = BUSY; #1;
            chk("t3_busy_ren", {31'b0, ramREN}, 1);
            chk("t3_busy_addr", ramaddr, 32'h40);
            chk("t3_busy_dwait", {31'b0, dwait}, 1);
        end
        @(negedge CLK); ramstate = ERR; #1;
        chk("t3_err_dwait", {31'b0, dwait}, 1);
        chk("t3_err_errcnt", {24'b0, err_cnt}, 0);
        @(negedge CLK); ramstate = FREE; #1;
        chk("t3_retry_ren", {31'b0, ramREN}, 0);
        chk("t3_retry_wen", {31'b0, ramWEN}, 0);
        chk("t3_retry_dwait", {31'b0, dwait}, 1);
        chk("t3_errcnt", {24'b0, err_cnt}, 1);
        @(negedge CLK); ramstate = ACC; ramload = 32'hCAFE; #1;
        chk("t3_reissue_ren", {31'b0, ramREN}, 1);
        chk("t3_reissue_addr", ramaddr, 32'h40);
        chk("t3_reissue_dwait", {31'b0, dwait}, 0);
        chk("t3_dload", dload, 32'hCAFE);

        // 300 ERROR responses, counter starting at 1, must stick at 255
        @(negedge CLK); ramstate = FREE;
        lows = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK); ramstate = ERR; #1;
            if (!dwait || !iwait) lows++;
        end
        chk("t4_no_wait_pulse", lows, 0);
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0, FREE, 0);
        @(negedge CLK); #1;
        chk("t4_errcnt_sat", {24'b0, err_cnt}, 255);
        chk("t4_idle_ren", {31'b0, ramREN}, 0);

        // async reset in the middle of a read
        @(negedge CLK); drive(0, 0, 1, 0, 32'h300, 0, BUSY, 0);
        @(negedge CLK); #1;
        chk("rst_mid_ren_before", {31'b0, ramREN}, 1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_mid_ren", {31'b0, ramREN}, 0);
        chk("rst_mid_addr", ramaddr, 0);
        chk("rst_mid_errcnt", {24'b0, err_cnt}, 0);
        @(negedge CLK); nRST = 1'b1; drive(0, 0, 0, 0, 0, 0, FREE, 0);

        // both caches requesting continuously with immediate ACCESS
        @(negedge CLK); drive(1, 32'h100, 1, 0, 32'h200, 0, ACC, 32'h9);
        got = "";
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!dwait && !iwait) lows++;
            if (!dwait) got = {got, "D"};
            if (!iwait) got = {got, "I"};
            @(negedge CLK);
        end
`ifdef ARB_FAIR_EN
        exp_s = "DIDI";
`else
        exp_s = "DDDD";
`endif
        checks++;
        if (got != exp_s) begin
            failures++;
            $display("FAIL t6_grant_order: got %s expected %s", got, exp_s);
        end
        chk("t6_never_both_low", lows, 0);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
